// File: rtl/nvdla_dbb_burst_splitter_pkg.sv
// Shared types for the DBB burst splitter.
// FSM state encoding lives here so the bench and RTL agree on names.
package nvdla_dbb_burst_splitter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_DATA,
    WR_RESP,
    B_OUT,
    RD_REQ,
    RD_DATA
  } dbb_split_state_t;

  function automatic int beat_bytes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/nvdla_dbb_burst_splitter_if.sv
// NVDLA-side burst channels and bridge-side single-beat channels.
// slave = splitter view, master = environment view.
interface nvdla_dbb_burst_splitter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 4
);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;

  logic                  s_aw_valid;
  logic                  s_aw_ready;
  logic [ADDR_WIDTH-1:0] s_aw_addr;
  logic [LEN_WIDTH-1:0]  s_aw_len;
  logic [ID_WIDTH-1:0]   s_aw_id;

  logic                  s_w_valid;
  logic                  s_w_ready;
  logic [DATA_WIDTH-1:0] s_w_data;
  logic [BEAT_BYTES-1:0] s_w_strb;
  logic                  s_w_last;

  logic                  s_b_valid;
  logic                  s_b_ready;
  logic [ID_WIDTH-1:0]   s_b_id;

  logic                  s_ar_valid;
  logic                  s_ar_ready;
  logic [ADDR_WIDTH-1:0] s_ar_addr;
  logic [LEN_WIDTH-1:0]  s_ar_len;
  logic [ID_WIDTH-1:0]   s_ar_id;

  logic                  s_r_valid;
  logic                  s_r_ready;
  logic [DATA_WIDTH-1:0] s_r_data;
  logic [ID_WIDTH-1:0]   s_r_id;
  logic                  s_r_last;

  logic                  m_wreq_valid;
  logic                  m_wreq_ready;
  logic [ADDR_WIDTH-1:0] m_wreq_addr;
  logic [ID_WIDTH-1:0]   m_wreq_id;

  logic                  m_wdat_valid;
  logic                  m_wdat_ready;
  logic [DATA_WIDTH-1:0] m_wdat_data;
  logic [BEAT_BYTES-1:0] m_wdat_strb;
  logic                  m_wdat_last;

  logic                  m_wrsp_valid;
  logic                  m_wrsp_ready;
  logic [ID_WIDTH-1:0]   m_wrsp_id;

  logic                  m_rreq_valid;
  logic                  m_rreq_ready;
  logic [ADDR_WIDTH-1:0] m_rreq_addr;
  logic [ID_WIDTH-1:0]   m_rreq_id;

  logic                  m_rdat_valid;
  logic                  m_rdat_ready;
  logic [DATA_WIDTH-1:0] m_rdat_data;
  logic [ID_WIDTH-1:0]   m_rdat_id;
  logic                  m_rdat_last;

  modport slave (
    input  s_aw_valid, s_aw_addr, s_aw_len, s_aw_id,
    output s_aw_ready,
    input  s_w_valid, s_w_data, s_w_strb, s_w_last,
    output s_w_ready,
    output s_b_valid, s_b_id,
    input  s_b_ready,
    input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_id,
    output s_ar_ready,
    output s_r_valid, s_r_data, s_r_id, s_r_last,
    input  s_r_ready,
    output m_wreq_valid, m_wreq_addr, m_wreq_id,
    input  m_wreq_ready,
    output m_wdat_valid, m_wdat_data, m_wdat_strb,
    output m_wdat_last,
    input  m_wdat_ready,
    input  m_wrsp_valid, m_wrsp_id,
    output m_wrsp_ready,
    output m_rreq_valid, m_rreq_addr, m_rreq_id,
    input  m_rreq_ready,
    input  m_rdat_valid, m_rdat_data, m_rdat_id,
    input  m_rdat_last,
    output m_rdat_ready
  );

  modport master (
    output s_aw_valid, s_aw_addr, s_aw_len, s_aw_id,
    input  s_aw_ready,
    output s_w_valid, s_w_data, s_w_strb, s_w_last,
    input  s_w_ready,
    input  s_b_valid, s_b_id,
    output s_b_ready,
    output s_ar_valid, s_ar_addr, s_ar_len, s_ar_id,
    input  s_ar_ready,
    input  s_r_valid, s_r_data, s_r_id, s_r_last,
    output s_r_ready,
    input  m_wreq_valid, m_wreq_addr, m_wreq_id,
    output m_wreq_ready,
    input  m_wdat_valid, m_wdat_data, m_wdat_strb,
    input  m_wdat_last,
    output m_wdat_ready,
    output m_wrsp_valid, m_wrsp_id,
    input  m_wrsp_ready,
    input  m_rreq_valid, m_rreq_addr, m_rreq_id,
    output m_rreq_ready,
    output m_rdat_valid, m_rdat_data, m_rdat_id,
    output m_rdat_last,
    input  m_rdat_ready
  );

endinterface

// File: rtl/nvdla_dbb_burst_splitter_beat_addr_gen.sv
// Burst base/len/beat counter shared by the read and write paths.
// Produces the current beat address and a last-beat flag.
module nvdla_dbb_beat_addr_gen
  import nvdla_dbb_burst_splitter_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 4,
  parameter int BEAT_BYTES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  is_last_o
);

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;

  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      base_d = base_i;
      len_d  = len_i;
      cnt_d  = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
    end
  end

  // wraps silently at 2^ADDR_WIDTH
  assign addr_o = base_q
                + ADDR_WIDTH'(cnt_q) * ADDR_WIDTH'(BEAT_BYTES);
  assign is_last_o = (cnt_q == len_q);

endmodule

// File: rtl/nvdla_dbb_burst_splitter.sv
// Splits NVDLA INCR bursts into single-beat bridge requests,
// merging per-beat write responses into one B per burst.
module nvdla_dbb_burst_splitter
  import nvdla_dbb_burst_splitter_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  nvdla_dbb_burst_splitter_if.slave  bus,
  output logic                       err_o
);

  localparam int BEAT_BYTES = beat_bytes(DATA_WIDTH);

  dbb_split_state_t      state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  err_q, err_d;
  logic                  load, step;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [LEN_WIDTH-1:0]  load_len;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  is_last;

  nvdla_dbb_beat_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .step_i    (step),
    .base_i    (load_addr),
    .len_i     (load_len),
    .addr_o    (beat_addr),
    .is_last_o (is_last)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    err_d     = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    load_addr = bus.s_aw_addr;
    load_len  = bus.s_aw_len;

    bus.s_aw_ready   = 1'b0;
    bus.s_ar_ready   = 1'b0;
    bus.s_w_ready    = 1'b0;
    bus.s_b_valid    = 1'b0;
    bus.s_b_id       = id_q;
    bus.s_r_valid    = 1'b0;
    bus.s_r_data     = bus.m_rdat_data;
    bus.s_r_id       = id_q;
    bus.s_r_last     = is_last;
    bus.m_wreq_valid = 1'b0;
    bus.m_wreq_addr  = beat_addr;
    bus.m_wreq_id    = id_q;
    bus.m_wdat_valid = 1'b0;
    bus.m_wdat_data  = bus.s_w_data;
    bus.m_wdat_strb  = bus.s_w_strb;
    bus.m_wdat_last  = 1'b1;
    bus.m_wrsp_ready = 1'b0;
    bus.m_rreq_valid = 1'b0;
    bus.m_rreq_addr  = beat_addr;
    bus.m_rreq_id    = id_q;
    bus.m_rdat_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.s_aw_ready = 1'b1;
        bus.s_ar_ready = 1'b1;
        // write wins a same-cycle tie
        if (bus.s_aw_valid) begin
          load    = 1'b1;
          id_d    = bus.s_aw_id;
          state_d = WR_REQ;
        end else if (bus.s_ar_valid) begin
          load      = 1'b1;
          load_addr = bus.s_ar_addr;
          load_len  = bus.s_ar_len;
          id_d      = bus.s_ar_id;
          state_d   = RD_REQ;
        end
      end
      WR_REQ: begin
        bus.m_wreq_valid = 1'b1;
        if (bus.m_wreq_ready) state_d = WR_DATA;
      end
      WR_DATA: begin
        bus.m_wdat_valid = bus.s_w_valid;
        bus.s_w_ready    = bus.m_wdat_ready;
        if (bus.s_w_valid && bus.m_wdat_ready) begin
          err_d   = (bus.s_w_last != is_last);
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        bus.m_wrsp_ready = 1'b1;
        if (bus.m_wrsp_valid) begin
          if (is_last) begin
            state_d = B_OUT;
          end else begin
            step    = 1'b1;
            state_d = WR_REQ;
          end
        end
      end
      B_OUT: begin
        bus.s_b_valid = 1'b1;
        if (bus.s_b_ready) state_d = IDLE;
      end
      RD_REQ: begin
        bus.m_rreq_valid = 1'b1;
        if (bus.m_rreq_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        bus.s_r_valid    = bus.m_rdat_valid;
        bus.m_rdat_ready = bus.s_r_ready;
        if (bus.m_rdat_valid && bus.s_r_ready) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            step    = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_nvdla_dbb_burst_splitter.sv
// Directed + randomized bench for the DBB burst splitter.
// One process drives both the NVDLA master and the bridge model.
module tb_nvdla_dbb_burst_splitter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  always #5 clk = ~clk;

  nvdla_dbb_burst_splitter_if bus ();

  nvdla_dbb_burst_splitter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .err_o (err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } wbeat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  id;
    logic        last;
  } rbeat_t;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int stall_pct  = 0;
  bit r_toggle   = 0;
  bit wdat_block = 0;

  logic        aw_pend = 0;
  logic [63:0] aw_addr = '0;
  logic [3:0]  aw_len  = '0;
  logic [7:0]  aw_id   = '0;
  logic        ar_pend = 0;
  logic [63:0] ar_addr = '0;
  logic [3:0]  ar_len  = '0;
  logic [7:0]  ar_id   = '0;
  wbeat_t      wq[$];

  int          wrsp_pend = 0;
  logic [63:0] rd_pend[$];

  logic [63:0] wreq_log[$];
  logic [63:0] rreq_log[$];
  wbeat_t      wdat_log[$];
  logic [7:0]  b_log[$];
  rbeat_t      r_log[$];
  int          err_beats[$];
  int          ar_hs_bcount = -1;
  bit          aw_hs_prev   = 0;

  function automatic logic [31:0] rdata(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [63:0] exp_addr(
    input logic [63:0] base, input int k);
    return base + 64'(k) * 64'd4;
  endfunction

  function automatic bit rnd_rdy();
    return $urandom_range(0, 99) >= stall_pct;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wreq_log.delete();
    rreq_log.delete();
    wdat_log.delete();
    b_log.delete();
    r_log.delete();
    err_beats.delete();
    ar_hs_bcount = -1;
  endtask

  task automatic tick();
    bit aw_hs, ar_hs, w_hs, wreq_hs, wdat_hs;
    bit wrsp_hs, b_hs, rreq_hs, rdat_hs;
    bus.s_aw_valid = aw_pend;
    bus.s_aw_addr  = aw_addr;
    bus.s_aw_len   = aw_len;
    bus.s_aw_id    = aw_id;
    bus.s_ar_valid = ar_pend;
    bus.s_ar_addr  = ar_addr;
    bus.s_ar_len   = ar_len;
    bus.s_ar_id    = ar_id;
    bus.s_w_valid  = (wq.size() > 0);
    bus.s_w_data   = wq.size() > 0 ? wq[0].data : '0;
    bus.s_w_strb   = wq.size() > 0 ? wq[0].strb : '0;
    bus.s_w_last   = wq.size() > 0 ? wq[0].last : 1'b0;
    bus.s_b_ready  = rnd_rdy();
    bus.s_r_ready  = r_toggle ? cyc[0] : rnd_rdy();
    bus.m_wreq_ready = rnd_rdy();
    bus.m_wdat_ready = wdat_block ? 1'b0 : rnd_rdy();
    bus.m_wrsp_valid = (wrsp_pend > 0);
    bus.m_wrsp_id    = 8'hA5;
    bus.m_rreq_ready = rnd_rdy();
    bus.m_rdat_valid = (rd_pend.size() > 0);
    bus.m_rdat_data  =
      rd_pend.size() > 0 ? rdata(rd_pend[0]) : '0;
    bus.m_rdat_id    = 8'hEE;
    bus.m_rdat_last  = 1'($urandom_range(0, 1));
    #1;
    if (aw_hs_prev)
      chk("wreq_latency", 64'(bus.m_wreq_valid), 64'd1);
    aw_hs_prev = 0;
    aw_hs   = bus.s_aw_valid && bus.s_aw_ready;
    ar_hs   = bus.s_ar_valid && bus.s_ar_ready && !aw_hs;
    w_hs    = bus.s_w_valid && bus.s_w_ready;
    wreq_hs = bus.m_wreq_valid && bus.m_wreq_ready;
    wdat_hs = bus.m_wdat_valid && bus.m_wdat_ready;
    wrsp_hs = bus.m_wrsp_valid && bus.m_wrsp_ready;
    b_hs    = bus.s_b_valid && bus.s_b_ready;
    rreq_hs = bus.m_rreq_valid && bus.m_rreq_ready;
    rdat_hs = bus.m_rdat_valid && bus.m_rdat_ready;
    if (aw_hs) begin
      aw_pend    = 0;
      aw_hs_prev = 1;
    end
    if (ar_hs) begin
      ar_pend      = 0;
      ar_hs_bcount = b_log.size();
    end
    if (w_hs) void'(wq.pop_front());
    if (wreq_hs) wreq_log.push_back(bus.m_wreq_addr);
    if (wdat_hs) begin
      wdat_log.push_back({bus.m_wdat_data,
                          bus.m_wdat_strb,
                          bus.m_wdat_last});
      wrsp_pend++;
    end
    if (wrsp_hs) wrsp_pend--;
    if (b_hs) b_log.push_back(bus.s_b_id);
    if (rreq_hs) begin
      rreq_log.push_back(bus.m_rreq_addr);
      rd_pend.push_back(bus.m_rreq_addr);
    end
    if (rdat_hs) begin
      void'(rd_pend.pop_front());
      r_log.push_back({bus.s_r_data, bus.s_r_id,
                       bus.s_r_last});
    end
    if (err) err_beats.push_back(wdat_log.size());
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_write(input logic [63:0] base,
                             input int len,
                             input logic [7:0] id,
                             input wbeat_t exp_w[$],
                             input int bad);
    chk("wr_nreq", 64'(wreq_log.size()), 64'(len + 1));
    chk("wr_ndat", 64'(wdat_log.size()), 64'(len + 1));
    for (int k = 0; k <= len; k++) begin
      if (k < wreq_log.size())
        chk("wr_addr", wreq_log[k], exp_addr(base, k));
      if (k < wdat_log.size()) begin
        chk("wr_data", 64'(wdat_log[k].data),
            64'(exp_w[k].data));
        chk("wr_strb", 64'(wdat_log[k].strb),
            64'(exp_w[k].strb));
        chk("wr_mlast", 64'(wdat_log[k].last), 64'd1);
      end
    end
    chk("b_count", 64'(b_log.size()), 64'd1);
    if (b_log.size() > 0)
      chk("b_id", 64'(b_log[0]), 64'(id));
    if (bad >= 0 && bad != len) begin
      chk("err_count", 64'(err_beats.size()), 64'd1);
      if (err_beats.size() > 0)
        chk("err_beat", 64'(err_beats[0]), 64'(bad + 1));
    end else begin
      chk("err_none", 64'(err_beats.size()), 64'd0);
    end
  endtask

  task automatic run_write(input logic [63:0] base,
                           input int len,
                           input logic [7:0] id,
                           input int bad);
    wbeat_t exp_w[$];
    wbeat_t b;
    clear_logs();
    aw_pend = 1;
    aw_addr = base;
    aw_len  = 4'(len);
    aw_id   = id;
    for (int k = 0; k <= len; k++) begin
      b.data = $urandom;
      b.strb = 4'($urandom_range(0, 15));
      b.last = (k == len) || (k == bad);
      wq.push_back(b);
      exp_w.push_back(b);
    end
    for (int c = 0; c < 3000 && b_log.size() == 0; c++)
      tick();
    for (int c = 0; c < 4; c++) tick();
    check_write(base, len, id, exp_w, bad);
  endtask

  task automatic check_read(input logic [63:0] base,
                            input int len,
                            input logic [7:0] id);
    chk("rd_nreq", 64'(rreq_log.size()), 64'(len + 1));
    chk("rd_nbeat", 64'(r_log.size()), 64'(len + 1));
    for (int k = 0; k <= len; k++) begin
      if (k < rreq_log.size())
        chk("rd_addr", rreq_log[k], exp_addr(base, k));
      if (k < r_log.size()) begin
        chk("rd_data", 64'(r_log[k].data),
            64'(rdata(exp_addr(base, k))));
        chk("rd_id", 64'(r_log[k].id), 64'(id));
        chk("rd_last", 64'(r_log[k].last),
            64'(k == len));
      end
    end
  endtask

  task automatic run_read(input logic [63:0] base,
                          input int len,
                          input logic [7:0] id);
    clear_logs();
    ar_pend = 1;
    ar_addr = base;
    ar_len  = 4'(len);
    ar_id   = id;
    for (int c = 0; c < 3000 && r_log.size() <= len; c++)
      tick();
    for (int c = 0; c < 4; c++) tick();
    check_read(base, len, id);
  endtask

  initial begin
    wbeat_t b;
    wbeat_t exp_w[$];
    logic [63:0] base;
    int len;
    bus.s_aw_valid = 0; bus.s_aw_addr = '0;
    bus.s_aw_len = '0;  bus.s_aw_id = '0;
    bus.s_ar_valid = 0; bus.s_ar_addr = '0;
    bus.s_ar_len = '0;  bus.s_ar_id = '0;
    bus.s_w_valid = 0;  bus.s_w_data = '0;
    bus.s_w_strb = '0;  bus.s_w_last = 0;
    bus.s_b_ready = 0;  bus.s_r_ready = 0;
    bus.m_wreq_ready = 0; bus.m_wdat_ready = 0;
    bus.m_wrsp_valid = 0; bus.m_wrsp_id = '0;
    bus.m_rreq_ready = 0; bus.m_rdat_valid = 0;
    bus.m_rdat_data = '0; bus.m_rdat_id = '0;
    bus.m_rdat_last = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_aw_ready", 64'(bus.s_aw_ready), 64'd1);
    chk("rst_ar_ready", 64'(bus.s_ar_ready), 64'd1);
    chk("rst_wreq_v", 64'(bus.m_wreq_valid), 64'd0);
    chk("rst_rreq_v", 64'(bus.m_rreq_valid), 64'd0);
    chk("rst_wdat_v", 64'(bus.m_wdat_valid), 64'd0);
    chk("rst_b_v", 64'(bus.s_b_valid), 64'd0);
    chk("rst_r_v", 64'(bus.s_r_valid), 64'd0);
    chk("rst_w_ready", 64'(bus.s_w_ready), 64'd0);
    chk("rst_wrsp_rdy", 64'(bus.m_wrsp_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 0;
    @(negedge clk);

    stall_pct = 0;
    run_write(64'h1000, 3, 8'h05, -1);
    run_read(64'h2000, 0, 8'h07);
    chk("rd_idle_again", 64'(bus.s_aw_ready), 64'd1);

    // simultaneous AW and AR
    clear_logs();
    aw_pend = 1; aw_addr = 64'h5000;
    aw_len = 4'd1; aw_id = 8'h11;
    ar_pend = 1; ar_addr = 64'h6000;
    ar_len = 4'd1; ar_id = 8'h22;
    exp_w.delete();
    for (int k = 0; k < 2; k++) begin
      b.data = $urandom;
      b.strb = 4'hF;
      b.last = (k == 1);
      wq.push_back(b);
      exp_w.push_back(b);
    end
    for (int c = 0; c < 3000 && r_log.size() < 2; c++)
      tick();
    for (int c = 0; c < 4; c++) tick();
    check_write(64'h5000, 1, 8'h11, exp_w, -1);
    chk("ar_after_b", 64'(ar_hs_bcount), 64'd1);
    check_read(64'h6000, 1, 8'h22);

    // bad W last on second beat
    run_write(64'h3000, 3, 8'h09, 1);

    // long read with backpressure
    stall_pct = 40;
    r_toggle  = 1;
    base = {32'($urandom), 32'($urandom)} & ~64'h3;
    run_read(base, 15, 8'($urandom));
    r_toggle = 0;

    for (int t = 0; t < 4; t++) begin
      stall_pct = 30;
      base = {32'($urandom), 32'($urandom)} & ~64'h3;
      len = $urandom_range(0, 15);
      if (t[0]) run_write(base, len, 8'($urandom), -1);
      else run_read(base, len, 8'($urandom));
    end

    // reset while a write sits in WR_DATA
    stall_pct  = 0;
    wdat_block = 1;
    clear_logs();
    aw_pend = 1; aw_addr = 64'h4000;
    aw_len = 4'd3; aw_id = 8'h33;
    for (int k = 0; k < 4; k++) begin
      b.data = $urandom; b.strb = 4'hF; b.last = (k == 3);
      wq.push_back(b);
    end
    for (int c = 0; c < 100 && wreq_log.size() == 0; c++)
      tick();
    tick();
    chk("pre_rst_wdat_v", 64'(bus.m_wdat_valid), 64'd1);
    #2;
    rst = 1;
    #1;
    chk("arst_wdat_v", 64'(bus.m_wdat_valid), 64'd0);
    chk("arst_wreq_v", 64'(bus.m_wreq_valid), 64'd0);
    chk("arst_rreq_v", 64'(bus.m_rreq_valid), 64'd0);
    chk("arst_b_v", 64'(bus.s_b_valid), 64'd0);
    chk("arst_r_v", 64'(bus.s_r_valid), 64'd0);
    chk("arst_aw_rdy", 64'(bus.s_aw_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    wdat_block = 0;
    wq.delete();
    wrsp_pend = 0;
    rd_pend.delete();
    aw_hs_prev = 0;
    @(negedge clk);
    chk("post_rst_nob", 64'(b_log.size()), 64'd0);
    run_write(64'hFFFF_FFFF_FFFF_FFF8, 3, 8'h3C, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
